bounce_ctrl: RTL and testbench
==============================

BOUNCE_CTRL -- requirements
Module: bounce_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- SCREEN_X, 640, playfield width px
- SCREEN_Y, 480, playfield height px
- PAD_W, 8, paddle width px
- PAD_H, 64, paddle height px
- PAD_L_X, 16, left paddle left edge x
- PAD_R_X, 616, right paddle left edge x
- COOL_TICKS, 8, ticks of bounce suppression after paddle/wall bounce (1..255)
- SERVE_TICKS, 60, ticks of silence after a goal (1..255)
- WIN_SCORE, 9, winning score (1..15)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle movement strobe, same rate at which the ball steps
- ball_x, ball_y  in  10  ball top-left corner
- ball_w, ball_h  in  8  ball size
- pad_l_y, pad_r_y  in  10  paddle top edges
- bounce  out  2  00 none, 01 paddle, 10 wall, 11 goal/re-serve
- score_l, score_r  out  4  player scores
- game_over  out  1  match finished

Function
REQ-003 All logic SHALL act only on rising clock edges; inputs SHALL be evaluated only in cycles with tick=1.
REQ-004 bounce SHALL be registered: it updates in the cycle after a tick and holds until the cycle after the next tick.
REQ-005 States SHALL be PLAY, COOLDOWN, SERVE and OVER.
REQ-006 Edge sums (x+w, y+h) SHALL be computed at 11 bits, with no truncation.
REQ-007 Paddle hit SHALL mean strict rectangle overlap of the ball with either paddle rectangle (x in [PAD_*_X, PAD_*_X+PAD_W), y in [pad_*_y, pad_*_y+PAD_H)).
REQ-008 Left goal SHALL be ball_x==0 or ball_x>=1008 (underflow); right goal SHALL be ball_x+ball_w>=SCREEN_X and not a left goal.
REQ-009 Wall hit SHALL be ball_y==0, ball_y>=1008, or ball_y+ball_h>=SCREEN_Y.
REQ-010 When several events coincide, priority SHALL be paddle > goal > wall.
REQ-011 PLAY on a tick:
- paddle hit -> bounce=01, enter COOLDOWN
- else goal -> bounce=11, enter SERVE, increment score_r (left goal) or score_l (right goal)
- else wall -> bounce=10, enter COOLDOWN
- else bounce=00
REQ-012 COOLDOWN SHALL last COOL_TICKS ticks with bounce=00 for paddle/wall; goals SHALL still be detected and handled as in REQ-011.
REQ-013 SERVE SHALL drive bounce=11 for its first tick period and 00 thereafter, then return to PLAY after SERVE_TICKS ticks.
REQ-014 A score increment that reaches WIN_SCORE SHALL enter OVER instead of SERVE, with bounce=11 for one tick period and then 00; OVER SHALL hold game_over=1 until reset.
REQ-015 A tick arriving in the same cycle as a state entry SHALL be counted by the new state starting from the next tick, never the same one.

Reset
REQ-016 reset SHALL override tick in the same cycle.
REQ-017 reset SHALL force state=PLAY, bounce=00, score_l=0, score_r=0, game_over=0 and all tick counters=0, including mid-COOLDOWN and mid-SERVE.

Configuration
REQ-018 With BOUNCE_WIN_LIMIT_EN defined, REQ-014 SHALL apply.
REQ-019 Without BOUNCE_WIN_LIMIT_EN:
- state OVER SHALL be absent
- game_over SHALL be tied to 0
- scores SHALL wrap modulo 16
- every goal SHALL enter SERVE

Structure
REQ-020 Package pong_pkg SHALL hold:
- bounce codes BOUNCE_NONE/PADDLE/WALL/GOAL
- SCREEN_X/SCREEN_Y defaults
- the state enum
REQ-021 Combinational sub-module rect_overlap SHALL be instantiated twice, once per paddle.

Verification
REQ-022 Ball at (300,0), size 30x30, tick -> bounce=10 one cycle later; next 8 ticks bounce=00.
REQ-023 Ball at (20,200), pad_l_y=190, tick -> bounce=01; ball at (0,200) on the same tick -> still 01 (paddle priority).
REQ-024 Ball at (0,100), pad_l_y=300, tick -> bounce=11 and score_r=1; 60 ticks of 00; then PLAY.
REQ-025 Nine right goals with the macro on -> score_l=9 and game_over=1; further goals leave the scores unchanged.
REQ-026 reset asserted 3 ticks into COOLDOWN together with a tick -> next cycle: bounce=00, scores 0, state PLAY.
REQ-027 Ball x+w=640 with y=0 (goal and wall at once) -> bounce=11, score_l incremented.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong bounce controller: bounce codes,
// default playfield size and the controller state enum.
// BOUNCE_WIN_LIMIT_EN adds the OVER state (match ends at a winning score).
package pong_pkg;

    localparam int DEF_SCREEN_X = 640;
    localparam int DEF_SCREEN_Y = 480;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_GOAL   = 2'b11;

`ifdef BOUNCE_WIN_LIMIT_EN
    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        COOLDOWN = 2'd1,
        SERVE    = 2'd2,
        OVER     = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        COOLDOWN = 2'd1,
        SERVE    = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/rect_overlap.sv
// Strict rectangle overlap between the ball and one fixed-size rectangle.
// Half-open intervals on both axes; all edge sums kept at 11 bits so a ball
// near the 10-bit limit cannot wrap into a false hit.
// Behaviour does not depend on BOUNCE_WIN_LIMIT_EN.
module rect_overlap #(
    parameter int RECT_W = 8,
    parameter int RECT_H = 64
) (
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    input  logic [7:0] ball_w_i,
    input  logic [7:0] ball_h_i,
    input  logic [9:0] rect_x_i,
    input  logic [9:0] rect_y_i,
    output logic       hit_o
);

    logic [10:0] ball_x_end;
    logic [10:0] ball_y_end;
    logic [10:0] rect_x_end;
    logic [10:0] rect_y_end;
    logic        x_ovl;
    logic        y_ovl;

    assign ball_x_end = {1'b0, ball_x_i} + {3'b000, ball_w_i};
    assign ball_y_end = {1'b0, ball_y_i} + {3'b000, ball_h_i};
    assign rect_x_end = {1'b0, rect_x_i} + 11'(RECT_W);
    assign rect_y_end = {1'b0, rect_y_i} + 11'(RECT_H);

    assign x_ovl = ({1'b0, ball_x_i} < rect_x_end) && ({1'b0, rect_x_i} < ball_x_end);
    assign y_ovl = ({1'b0, ball_y_i} < rect_y_end) && ({1'b0, rect_y_i} < ball_y_end);
    assign hit_o = x_ovl && y_ovl;

endmodule

// File: rtl/bounce_ctrl.sv
// Pong ball event controller: classifies the ball position on each movement
// tick into paddle / wall / goal events, keeps score and times the bounce
// suppression and re-serve windows.
// BOUNCE_WIN_LIMIT_EN: when defined the match stops in OVER once a player
// reaches WIN_SCORE; otherwise scores wrap modulo 16 and play never ends.
module bounce_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_X    = DEF_SCREEN_X,
    parameter int SCREEN_Y    = DEF_SCREEN_Y,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 64,
    parameter int PAD_L_X     = 16,
    parameter int PAD_R_X     = 616,
    parameter int COOL_TICKS  = 8,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_w,
    input  logic [7:0] ball_h,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    output logic [1:0] bounce,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    // Reject out-of-range configurations at elaboration time.
    if (COOL_TICKS < 1 || COOL_TICKS > 255 || SERVE_TICKS < 1 || SERVE_TICKS > 255 ||
        WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_cfg
        $error("bounce_ctrl: COOL_TICKS/SERVE_TICKS must be 1..255, WIN_SCORE 1..15");
    end

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  bounce_q, bounce_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;

    logic        hit_l, hit_r, pad_hit;
    logic        goal_l, goal_r, goal, wall;
    logic        cooling;
    logic [10:0] x_end, y_end;
    logic [3:0]  score_l_inc, score_r_inc;

    rect_overlap #(.RECT_W(PAD_W), .RECT_H(PAD_H)) u_pad_l (
        .ball_x_i (ball_x),
        .ball_y_i (ball_y),
        .ball_w_i (ball_w),
        .ball_h_i (ball_h),
        .rect_x_i (10'(PAD_L_X)),
        .rect_y_i (pad_l_y),
        .hit_o    (hit_l)
    );

    rect_overlap #(.RECT_W(PAD_W), .RECT_H(PAD_H)) u_pad_r (
        .ball_x_i (ball_x),
        .ball_y_i (ball_y),
        .ball_w_i (ball_w),
        .ball_h_i (ball_h),
        .rect_x_i (10'(PAD_R_X)),
        .rect_y_i (pad_r_y),
        .hit_o    (hit_r)
    );

    // Event classification; x >= 1008 / y >= 1008 catch a ball that stepped
    // past zero and wrapped around.
    assign x_end   = {1'b0, ball_x} + {3'b000, ball_w};
    assign y_end   = {1'b0, ball_y} + {3'b000, ball_h};
    assign pad_hit = hit_l || hit_r;
    assign goal_l  = (ball_x == 10'd0) || (ball_x >= 10'd1008);
    assign goal_r  = (x_end >= 11'(SCREEN_X)) && !goal_l;
    assign goal    = goal_l || goal_r;
    assign wall    = (ball_y == 10'd0) || (ball_y >= 10'd1008) || (y_end >= 11'(SCREEN_Y));
    assign cooling = (state_q == COOLDOWN);

    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    // Next-state: everything advances only on tick; bounce is cleared each
    // tick unless a new event is raised. Entry ticks start counters at zero,
    // so a state is first counted on the tick after it was entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bounce_d  = bounce_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        if (tick) begin
            bounce_d = BOUNCE_NONE;
            case (state_q)
                PLAY, COOLDOWN: begin
                    if (pad_hit && !cooling) begin
                        bounce_d = BOUNCE_PADDLE;
                        state_d  = COOLDOWN;
                        cnt_d    = 8'd0;
                    end else if (goal && !pad_hit) begin
                        // A paddle overlap outranks the goal even while
                        // its own bounce is being suppressed.
                        bounce_d = BOUNCE_GOAL;
                        state_d  = SERVE;
                        cnt_d    = 8'd0;
                        if (goal_l) score_r_d = score_r_inc;
                        else        score_l_d = score_l_inc;
`ifdef BOUNCE_WIN_LIMIT_EN
                        if ((goal_l && score_r_inc == 4'(WIN_SCORE)) ||
                            (goal_r && score_l_inc == 4'(WIN_SCORE))) begin
                            state_d = OVER;
                        end
`endif
                    end else if (wall && !cooling) begin
                        bounce_d = BOUNCE_WALL;
                        state_d  = COOLDOWN;
                        cnt_d    = 8'd0;
                    end else if (cooling) begin
                        if (cnt_q == 8'(COOL_TICKS - 1)) begin
                            state_d = PLAY;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                SERVE: begin
                    if (cnt_q == 8'(SERVE_TICKS - 1)) begin
                        state_d = PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`ifdef BOUNCE_WIN_LIMIT_EN
                OVER: begin
                    state_d = OVER;
                end
`endif
                default: begin
                    state_d = PLAY;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // State register; reset wins over a coincident tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= PLAY;
            cnt_q     <= 8'd0;
            bounce_q  <= BOUNCE_NONE;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bounce_q  <= bounce_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign bounce  = bounce_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
`ifdef BOUNCE_WIN_LIMIT_EN
    assign game_over = (state_q == OVER);
`else
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_bounce_ctrl.sv
// Self-checking bench for bounce_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the game rules.
// Works with or without BOUNCE_WIN_LIMIT_EN defined.
module tb_bounce_ctrl;

    localparam int COOL  = 8;
    localparam int SERVE = 60;
    localparam int WIN   = 9;
`ifdef BOUNCE_WIN_LIMIT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic [9:0] ball_x = 10'd300, ball_y = 10'd200;
    logic [7:0] ball_w = 8'd10, ball_h = 8'd10;
    logic [9:0] pad_l_y = 10'd0, pad_r_y = 10'd0;
    logic [1:0] bounce;
    logic [3:0] score_l, score_r;
    logic       game_over;

    int vectors = 0;
    int miscompares = 0;

    bounce_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .ball_w    (ball_w),
        .ball_h    (ball_h),
        .pad_l_y   (pad_l_y),
        .pad_r_y   (pad_r_y),
        .bounce    (bounce),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    // mode: 0 normal play, 1 bounce suppressed, 2 waiting for serve, 3 match over.
    // rem counts ticks still to spend in modes 1 and 2.
    int m_mode, m_rem, m_bounce, m_sl, m_sr;

    function automatic bit overlap(int bx, int by, int bw, int bh, int rx, int ry, int rw, int rh);
        return (bx < rx + rw) && (rx < bx + bw) && (by < ry + rh) && (ry < by + bh);
    endfunction

    function void model_reset();
        m_mode = 0; m_rem = 0; m_bounce = 0; m_sl = 0; m_sr = 0;
    endfunction

    function void model_tick();
        int x, y, w, h;
        bit pad, lg, rg, wl, won;
        x = int'(ball_x); y = int'(ball_y); w = int'(ball_w); h = int'(ball_h);
        pad = overlap(x, y, w, h, 16, int'(pad_l_y), 8, 64) ||
              overlap(x, y, w, h, 616, int'(pad_r_y), 8, 64);
        lg  = (x == 0) || (x >= 1008);
        rg  = (x + w >= 640) && !lg;
        wl  = (y == 0) || (y >= 1008) || (y + h >= 480);
        m_bounce = 0;
        if (m_mode == 3) begin
            // match finished: nothing happens
        end else if (m_mode == 2) begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end else if (pad && m_mode == 0) begin
            m_bounce = 1; m_mode = 1; m_rem = COOL;
        end else if ((lg || rg) && !pad) begin
            m_bounce = 3;
            if (lg) m_sr = (m_sr + 1) % 16; else m_sl = (m_sl + 1) % 16;
            won = WIN_EN && ((lg && m_sr == WIN) || (rg && m_sl == WIN));
            if (won) m_mode = 3;
            else begin m_mode = 2; m_rem = SERVE; end
        end else if (wl && m_mode == 0) begin
            m_bounce = 2; m_mode = 1; m_rem = COOL;
        end else if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
    endfunction

    // One clock: inputs change on the falling edge, outputs are looked at
    // just after the following rising edge.
    task automatic drive(input bit tk, input bit rst, input int x, input int y, input int w, input int h);
        @(negedge clock);
        tick = tk; reset = rst;
        ball_x = 10'(x); ball_y = 10'(y); ball_w = 8'(w); ball_h = 8'(h);
        @(posedge clock);
        #1;
        if (rst) model_reset();
        else if (tk) model_tick();
    endtask

    task automatic do_reset();
        pad_l_y = 10'd0; pad_r_y = 10'd0;
        drive(1'b0, 1'b1, 300, 200, 10, 10);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 0, 100, 10, 10);
        vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL reset_bounce: got %b want 00", bounce); end
        vectors++; if (score_l !== 4'd0 || score_r !== 4'd0) begin miscompares++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_l, score_r); end
        vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL reset_play: got %b want 10", bounce); end
    endtask

    task automatic test_wall();
        do_reset();
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL wall_top: got %b want 10", bounce); end
        drive(1'b0, 1'b0, 300, 0, 30, 30);
        drive(1'b0, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL wall_hold: got %b want 10", bounce); end
        for (int i = 0; i < COOL; i++) begin
            drive(1'b1, 1'b0, 300, 0, 30, 30);
            vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL wall_cool[%0d]: got %b want 00", i, bounce); end
        end
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL wall_after_cool: got %b want 10", bounce); end
        do_reset();
        drive(1'b1, 1'b0, 300, 450, 8'd30, 8'd30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL wall_bottom: got %b want 10", bounce); end
        do_reset();
        drive(1'b1, 1'b0, 300, 449, 30, 30);
        vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL wall_bottom_miss: got %b want 00", bounce); end
        drive(1'b1, 1'b0, 300, 1010, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL wall_underflow: got %b want 10", bounce); end
    endtask

    task automatic test_paddle();
        do_reset();
        pad_l_y = 10'd190;
        drive(1'b1, 1'b0, 20, 200, 30, 30);
        vectors++; if (bounce !== 2'b01) begin miscompares++; $display("FAIL paddle_left: got %b want 01", bounce); end
        do_reset();
        pad_l_y = 10'd190;
        drive(1'b1, 1'b0, 0, 200, 30, 30);
        vectors++; if (bounce !== 2'b01 || score_r !== 4'd0) begin miscompares++; $display("FAIL paddle_priority: got %b/%0d want 01/0", bounce, score_r); end
        do_reset();
        pad_r_y = 10'd295;
        drive(1'b1, 1'b0, 610, 300, 10, 10);
        vectors++; if (bounce !== 2'b01) begin miscompares++; $display("FAIL paddle_right: got %b want 01", bounce); end
        do_reset();
        pad_l_y = 10'd190;
        drive(1'b1, 1'b0, 20, 254, 10, 10);
        vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL paddle_edge_miss: got %b want 00", bounce); end
        drive(1'b1, 1'b0, 24, 200, 10, 10);
        vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL paddle_xedge_miss: got %b want 00", bounce); end
    endtask

    task automatic test_goal();
        do_reset();
        pad_l_y = 10'd300;
        drive(1'b1, 1'b0, 0, 100, 10, 10);
        vectors++; if (bounce !== 2'b11 || score_r !== 4'd1 || score_l !== 4'd0) begin miscompares++; $display("FAIL goal_left: got %b %0d/%0d want 11 0/1", bounce, score_l, score_r); end
        for (int i = 0; i < SERVE; i++) begin
            drive(1'b1, 1'b0, 0, 100, 10, 10);
            vectors++; if (bounce !== 2'b00 || score_r !== 4'd1) begin miscompares++; $display("FAIL goal_serve[%0d]: got %b/%0d want 00/1", i, bounce, score_r); end
        end
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL goal_back_to_play: got %b want 10", bounce); end
        do_reset();
        drive(1'b1, 1'b0, 1012, 100, 10, 10);
        vectors++; if (bounce !== 2'b11 || score_r !== 4'd1) begin miscompares++; $display("FAIL goal_underflow: got %b/%0d want 11/1", bounce, score_r); end
    endtask

    task automatic test_corner();
        do_reset();
        drive(1'b1, 1'b0, 629, 200, 10, 10);
        vectors++; if (bounce !== 2'b00) begin miscompares++; $display("FAIL right_edge_miss: got %b want 00", bounce); end
        drive(1'b1, 1'b0, 630, 0, 10, 10);
        vectors++; if (bounce !== 2'b11 || score_l !== 4'd1 || score_r !== 4'd0) begin miscompares++; $display("FAIL corner_goal_wall: got %b %0d/%0d want 11 1/0", bounce, score_l, score_r); end
    endtask

    task automatic test_win();
        do_reset();
        for (int g = 0; g < WIN; g++) begin
            drive(1'b1, 1'b0, 630, 200, 10, 10);
            vectors++; if (bounce !== 2'b11) begin miscompares++; $display("FAIL win_goal[%0d]: got %b want 11", g, bounce); end
            if (g < WIN - 1)
                for (int i = 0; i < SERVE; i++) drive(1'b1, 1'b0, 300, 200, 10, 10);
        end
        vectors++; if (score_l !== 4'd9) begin miscompares++; $display("FAIL win_score: got %0d want 9", score_l); end
`ifdef BOUNCE_WIN_LIMIT_EN
        vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL win_game_over: got %b want 1", game_over); end
        for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 630, 200, 10, 10);
        vectors++; if (bounce !== 2'b00 || score_l !== 4'd9 || score_r !== 4'd0 || game_over !== 1'b1) begin
            miscompares++; $display("FAIL win_frozen: got %b %0d/%0d go=%b want 00 9/0 go=1", bounce, score_l, score_r, game_over); end
`else
        vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL win_game_over: got %b want 0", game_over); end
        for (int g = 0; g < 7; g++) begin
            for (int i = 0; i < SERVE; i++) drive(1'b1, 1'b0, 300, 200, 10, 10);
            drive(1'b1, 1'b0, 630, 200, 10, 10);
        end
        vectors++; if (score_l !== 4'd0 || bounce !== 2'b11) begin miscompares++; $display("FAIL win_wrap: got %0d/%b want 0/11", score_l, bounce); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 630, 200, 10, 10);
        for (int i = 0; i < SERVE; i++) drive(1'b1, 1'b0, 300, 200, 10, 10);
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 300, 0, 30, 30);
        drive(1'b1, 1'b1, 0, 100, 10, 10);
        vectors++; if (bounce !== 2'b00 || score_l !== 4'd0 || score_r !== 4'd0) begin
            miscompares++; $display("FAIL reset_mid_cool: got %b %0d/%0d want 00 0/0", bounce, score_l, score_r); end
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10) begin miscompares++; $display("FAIL reset_mid_cool_play: got %b want 10", bounce); end
        do_reset();
        drive(1'b1, 1'b0, 0, 100, 10, 10);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 300, 200, 10, 10);
        drive(1'b1, 1'b1, 300, 200, 10, 10);
        drive(1'b1, 1'b0, 300, 0, 30, 30);
        vectors++; if (bounce !== 2'b10 || score_r !== 4'd0) begin miscompares++; $display("FAIL reset_mid_serve: got %b/%0d want 10/0", bounce, score_r); end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        int x, y, w, h, cat;
        bit tk, rst;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            tk  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 399) == 0);
            w   = $urandom_range(1, 40);
            h   = $urandom_range(1, 40);
            if ($urandom_range(0, 19) == 0) begin
                pad_l_y = 10'($urandom_range(0, 420));
                pad_r_y = 10'($urandom_range(0, 420));
            end
            cat = $urandom_range(0, 5);
            case (cat)
                0: begin x = $urandom_range(40, 560); y = $urandom_range(5, 430); end
                1: begin x = $urandom_range(0, 30); y = int'(pad_l_y) + $urandom_range(0, 100) - 40; end
                2: begin x = $urandom_range(580, 630); y = int'(pad_r_y) + $urandom_range(0, 100) - 40; end
                3: begin x = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1005, 1023); y = $urandom_range(0, 470); end
                4: begin x = 640 - w + $urandom_range(0, 3) - 1; y = $urandom_range(0, 470); end
                default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
            endcase
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            drive(tk, rst, x, y, w, h);
            vectors++;
            if (bounce !== 2'(m_bounce) || score_l !== 4'(m_sl) || score_r !== 4'(m_sr) ||
                game_over !== (m_mode == 3)) begin
                miscompares++;
                $display("FAIL random[%0d]: got b=%b sl=%0d sr=%0d go=%b want b=%0d sl=%0d sr=%0d go=%0d",
                         n, bounce, score_l, score_r, game_over, m_bounce, m_sl, m_sr, (m_mode == 3));
            end
        end
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b1, 300, 200, 10, 10);
        drive(1'b0, 1'b1, 300, 200, 10, 10);
        test_reset();
        test_wall();
        test_paddle();
        test_goal();
        test_corner();
        test_win();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
